// File: rtl/io_input_buffer_pkg.sv
// Shared definitions for the io_input prefetch buffer: word width, default
// FIFO geometry and the fetch handshake state encoding.
package io_input_buffer_pkg;

    localparam int WORD_SIZE   = 16;
    localparam int IO_DEPTH    = 4;
    localparam int IO_PTR_BITS = 2;

    // Fetch FSM states for the 4-phase requester side of the io_input handshake.
    typedef enum logic [1:0] {
        F_IDLE = 2'd0,
        F_REQ  = 2'd1,
        F_REL  = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/io_fifo.sv
// io_fifo: DEPTH x WIDTH circular byte store with occupancy count.
// Pushes into a full FIFO and pops from an empty one are ignored, so count
// stays within 0..DEPTH. The head entry is presented combinationally.
module io_fifo
    import io_input_buffer_pkg::*;
#(
    parameter int DEPTH    = IO_DEPTH,
    parameter int PTR_BITS = IO_PTR_BITS,
    parameter int WIDTH    = WORD_SIZE
) (
    input  logic                clk,
    input  logic                areset,
    input  logic                push,
    input  logic [WIDTH-1:0]    push_data,
    input  logic                pop,
    output logic [WIDTH-1:0]    head,
    output logic [PTR_BITS:0]   count
);

    localparam logic [PTR_BITS:0] FULL_COUNT = (PTR_BITS+1)'(DEPTH);

    logic [WIDTH-1:0]    mem [DEPTH];
    logic [PTR_BITS-1:0] wr_ptr;
    logic [PTR_BITS-1:0] rd_ptr;
    logic                do_push;
    logic                do_pop;

    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != FULL_COUNT) || do_pop);
    assign head    = mem[rd_ptr];

    // Storage write and pointer/occupancy update; pointers wrap modulo DEPTH.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/io_input_buffer.sv
// io_input_buffer: prefetching byte buffer between io_input and the CPU's
// memory-mapped input port. Requests bytes over the 4-phase req/ack
// handshake while there is room, and turns CPU reads into single
// request / single valid transactions; EOF_VALUE is returned once the
// upstream has reported EOF and the FIFO is drained.
// Optional build macro: IO_INPUT_DROP_CR_EN discards acked 0x0D bytes.
//
// state  | meaning
// F_IDLE | no request out; launch when room, no EOF yet, and ack low
// F_REQ  | in_req high, waiting for in_ack to capture byte or EOF
// F_REL  | in_req low, waiting for in_ack to fall
module io_input_buffer
    import io_input_buffer_pkg::*;
#(
    parameter int                   DEPTH     = IO_DEPTH,
    parameter int                   PTR_BITS  = IO_PTR_BITS,
    parameter logic [WORD_SIZE-1:0] EOF_VALUE = '1
) (
    input  logic                  clk,
    input  logic                  areset,
    output logic                  in_req,
    input  logic                  in_ack,
    input  logic [WORD_SIZE-1:0]  in_data,
    input  logic                  in_eof,
    input  logic                  rd_req,
    output logic [WORD_SIZE-1:0]  rd_data,
    output logic                  rd_valid,
    output logic                  rd_busy,
    output logic [PTR_BITS:0]     count,
    output logic                  eof_seen
);

    localparam logic [PTR_BITS:0] FULL_COUNT = (PTR_BITS+1)'(DEPTH);

    fetch_state_t         state_q;
    fetch_state_t         state_d;
    logic                 push;
    logic                 set_eof;
    logic                 pop;
    logic                 drop_byte;
    logic [WORD_SIZE-1:0] head;

`ifdef IO_INPUT_DROP_CR_EN
    assign drop_byte = (in_data[7:0] == 8'h0D);
`else
    assign drop_byte = 1'b0;
`endif

    assign in_req = (state_q == F_REQ);
    assign pop    = rd_busy && (count != '0);

    io_fifo #(
        .DEPTH    (DEPTH),
        .PTR_BITS (PTR_BITS),
        .WIDTH    (WORD_SIZE)
    ) u_fifo (
        .clk       (clk),
        .areset    (areset),
        .push      (push),
        .push_data (in_data),
        .pop       (pop),
        .head      (head),
        .count     (count)
    );

    // Fetch FSM state register; reset abandons any handshake in flight.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_q <= F_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Fetch FSM next state; room is checked only at launch since a single
    // outstanding request can never overfill the FIFO.
    always_comb begin
        state_d = state_q;
        push    = 1'b0;
        set_eof = 1'b0;
        case (state_q)
            F_IDLE: begin
                if (!eof_seen && (count != FULL_COUNT) && !in_ack) begin
                    state_d = F_REQ;
                end
            end
            F_REQ: begin
                if (in_ack) begin
                    state_d = F_REL;
                    if (in_eof) begin
                        set_eof = 1'b1;
                    end else if (!drop_byte) begin
                        push = 1'b1;
                    end
                end
            end
            F_REL: begin
                if (!in_ack) begin
                    state_d = F_IDLE;
                end
            end
            default: state_d = F_IDLE;
        endcase
    end

    // Sticky end-of-file flag; cleared only by reset.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            eof_seen <= 1'b0;
        end else if (set_eof) begin
            eof_seen <= 1'b1;
        end
    end

    // Read path: accept a request when idle, then deliver the head byte or
    // EOF_VALUE once available; a push is seen one cycle later (no bypass).
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            rd_busy  <= 1'b0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= 1'b0;
            if (rd_busy) begin
                if (count != '0) begin
                    rd_data  <= head;
                    rd_valid <= 1'b1;
                    rd_busy  <= 1'b0;
                end else if (eof_seen) begin
                    rd_data  <= EOF_VALUE;
                    rd_valid <= 1'b1;
                    rd_busy  <= 1'b0;
                end
            end else if (rd_req) begin
                rd_busy <= 1'b1;
            end
        end
    end

endmodule
